bcd_score_counter: RTL
======================

Name: bcd_score_counter

Overview:
- Game score register sitting directly downstream of bcd_ripple_carry_adder. It instantiates one adder and registers the adder's sum as the running BCD score.
- Tracks the session best score, saturates on overflow, and rejects malformed BCD increments.
- Streams a snapshot of the score digit-by-digit (MSB first, with leading-zero blank flags) to the text/sprite renderer over a valid/ready handshake.

Parameters:
- DIGITS_COUNT, 4: number of BCD digits in score, best_score and add_value (must be >= 2).

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous active-high reset.
- clear  input  1  game restart. Zeroes score and overflow only.
- add_valid  input  1  increment request.
- add_value  input  DIGITS_COUNT*4  BCD increment.
- add_ready  output  1  increment accepted when add_valid && add_ready.
- add_error  output  1  one-cycle pulse: accepted add_value contained a nibble > 9.
- score  output  DIGITS_COUNT*4  current BCD score (registered).
- best_score  output  DIGITS_COUNT*4  highest score since rst (registered).
- new_best  output  1  one-cycle pulse when best_score changes.
- overflow  output  1  sticky: score saturated.
- dump_start  input  1  request digit stream of the current score.
- busy  output  1  stream in progress.
- digit_valid  output  1  digit_* fields valid.
- digit_ready  input  1  renderer consumes digit when digit_valid && digit_ready.
- digit_data  output  4  BCD digit.
- digit_index  output  $clog2(DIGITS_COUNT)  digit position, DIGITS_COUNT-1 = MSD, 0 = LSD.
- digit_blank  output  1  leading zero; renderer draws nothing.
- digit_last  output  1  digit_index == 0.

Behaviour:
- Reset (rst high at a clk edge): all outputs and internal state go to 0, including score, best_score, overflow, busy, digit_valid, add_error and new_best. Dump FSM goes to IDLE. rst overrides every other input and aborts a stream in progress.
- add_ready = !clear. This is combinational.

Clear:
- A clear cycle sets score to 0 and overflow to 0.
- best_score is not affected.
- Any add_valid in the same cycle is dropped (add_ready is low).

Add path:
- On an accepted add with every add_value nibble <= 9, the adder computes score + add_value with cin = 0.
  - cout == 0: score <= sum.
  - cout == 1: score <= all nibbles 9, and overflow <= 1.
  - Once overflow is set, score stays at all 9s until clear or rst.
- On an accepted add with any nibble > 9: score is unchanged, and add_error pulses in the next cycle.
- Latency: score reflects the add on the first clk edge after acceptance. Back-to-back adds, one per cycle, are supported.

Best score:
- Comparison uses the registered score. When score > best_score (unsigned compare of the packed BCD vectors), best_score <= score one cycle after score changes.
- new_best is asserted in that same cycle.
- best_score lags score by one cycle.

Dump FSM, states IDLE and STREAM:
- IDLE:
  - busy = 0 and digit_valid = 0.
  - When dump_start = 1, the registered score is captured into a snapshot, digit_index is set to DIGITS_COUNT-1, and the FSM moves to STREAM.
- STREAM:
  - busy = 1 and digit_valid = 1.
  - digit_data = snapshot nibble at digit_index.
  - digit_* are held stable while digit_ready = 0.
  - On a handshake, digit_index decrements.
  - A handshake with digit_last = 1 returns the FSM to IDLE, with digit_valid low on the next cycle.
  - dump_start is ignored while in STREAM.
- Stream coherence: adds and clear during STREAM update score but never the snapshot, so the streamed digits are a consistent snapshot.
- Blanking: digit_blank = 1 iff the current digit is 0, every higher snapshot digit is 0, and digit_index != 0. The LSD is never blanked, so score 0 shows a single "0".
- A new dump may start in the cycle after the last handshake.

Test Plan:
1. rst, then add 0x0005 four times back-to-back -> score sequence 0005, 0010, 0015, 0020 on consecutive cycles. best_score follows one cycle later. new_best pulses 4 times.
2. score=9990, add 0x0015 -> score 9999, overflow=1. A further add 0x0001 -> score stays 9999. Then clear -> score 0000, overflow 0, best_score 9999.
3. add 0x00A3 -> add_error pulses one cycle later and score is unchanged. clear+add_valid in the same cycle -> add_ready=0, score 0000.
4. score=0042, dump_start, digit_ready=1 -> (idx3,0,blank), (idx2,0,blank), (idx1,4,no), (idx0,2,no,last). busy low after the 4th handshake.
5. score=0000 dump -> indices 3..1 blank, idx0 digit 0 not blank. digit_ready held low 5 cycles at idx2 -> outputs stable. An add of 0x0100 during the stream -> streamed digits remain 0000.
6. rst asserted mid-stream (at idx2) -> next cycle: busy=0, digit_valid=0, score=0, best_score=0.

Source files
------------

// File: rtl/bcd_score_counter.sv
// BCD game score register with session best, overflow saturation,
// malformed-increment rejection and a digit-serial snapshot stream
// (MSD first, leading-zero blanking) for the text/sprite renderer.

// Ripple-carry BCD adder: one decimal digit per stage, carry chained upward.
module bcd_ripple_carry_adder #(
    parameter int DIGITS_COUNT = 4
) (
    input  logic [DIGITS_COUNT*4-1:0] a,
    input  logic [DIGITS_COUNT*4-1:0] b,
    input  logic                      cin,
    output logic [DIGITS_COUNT*4-1:0] sum,
    output logic                      cout
);

    logic [DIGITS_COUNT:0] carry;

    assign carry[0] = cin;

    generate
        for (genvar gi = 0; gi < DIGITS_COUNT; gi++) begin : g_digit
            logic [4:0] raw;
            logic       adjust;

            // Binary digit sum, then +6 correction whenever it leaves 0..9.
            assign raw    = {1'b0, a[gi*4 +: 4]} + {1'b0, b[gi*4 +: 4]} + {4'd0, carry[gi]};
            assign adjust = (raw > 5'd9);
            assign sum[gi*4 +: 4] = adjust ? 4'(raw + 5'd6) : raw[3:0];
            assign carry[gi+1]    = adjust;
        end
    endgenerate

    assign cout = carry[DIGITS_COUNT];

endmodule

module bcd_score_counter #(
    parameter int DIGITS_COUNT = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           clear,
    input  logic                           add_valid,
    input  logic [DIGITS_COUNT*4-1:0]      add_value,
    output logic                           add_ready,
    output logic                           add_error,
    output logic [DIGITS_COUNT*4-1:0]      score,
    output logic [DIGITS_COUNT*4-1:0]      best_score,
    output logic                           new_best,
    output logic                           overflow,
    input  logic                           dump_start,
    output logic                           busy,
    output logic                           digit_valid,
    input  logic                           digit_ready,
    output logic [3:0]                     digit_data,
    output logic [$clog2(DIGITS_COUNT)-1:0] digit_index,
    output logic                           digit_blank,
    output logic                           digit_last
);

    localparam int W  = DIGITS_COUNT * 4;
    localparam int IW = $clog2(DIGITS_COUNT);
    localparam logic [W-1:0]  ALL_NINES = {DIGITS_COUNT{4'd9}};
    localparam logic [IW-1:0] TOP_INDEX = IW'(DIGITS_COUNT - 1);

    // ------------------------------------------------------------------
    // Add path
    // ------------------------------------------------------------------
    logic [W-1:0]            score_reg;
    logic                    overflow_reg;
    logic                    add_error_reg;
    logic [W-1:0]            adder_sum;
    logic                    adder_cout;
    logic [DIGITS_COUNT-1:0] nibble_bad;
    logic                    add_accept;
    logic                    add_bcd_ok;

    // A restart cycle refuses increments so clear always wins.
    assign add_ready  = !clear;
    assign add_accept = add_valid && add_ready;

    generate
        for (genvar gi = 0; gi < DIGITS_COUNT; gi++) begin : g_nibble_check
            assign nibble_bad[gi] = (add_value[gi*4 +: 4] > 4'd9);
        end
    endgenerate

    assign add_bcd_ok = ~|nibble_bad;

    bcd_ripple_carry_adder #(
        .DIGITS_COUNT(DIGITS_COUNT)
    ) u_adder (
        .a    (score_reg),
        .b    (add_value),
        .cin  (1'b0),
        .sum  (adder_sum),
        .cout (adder_cout)
    );

    // Score register: clear, saturating accumulate, malformed-add rejection.
    always_ff @(posedge clk) begin
        if (rst) begin
            score_reg     <= '0;
            overflow_reg  <= 1'b0;
            add_error_reg <= 1'b0;
        end else begin
            add_error_reg <= add_accept && !add_bcd_ok;
            if (clear) begin
                score_reg    <= '0;
                overflow_reg <= 1'b0;
            end else if (add_accept && add_bcd_ok) begin
                // Once saturated the score is pinned at all nines until clear.
                if (overflow_reg || adder_cout) begin
                    score_reg    <= ALL_NINES;
                    overflow_reg <= 1'b1;
                end else begin
                    score_reg <= adder_sum;
                end
            end
        end
    end

    assign score     = score_reg;
    assign overflow  = overflow_reg;
    assign add_error = add_error_reg;

    // ------------------------------------------------------------------
    // Session best: packed BCD compares correctly as plain unsigned.
    // ------------------------------------------------------------------
    logic [W-1:0] best_reg;
    logic         new_best_reg;

    // Best tracker runs one cycle behind the registered score.
    always_ff @(posedge clk) begin
        if (rst) begin
            best_reg     <= '0;
            new_best_reg <= 1'b0;
        end else if (score_reg > best_reg) begin
            best_reg     <= score_reg;
            new_best_reg <= 1'b1;
        end else begin
            new_best_reg <= 1'b0;
        end
    end

    assign best_score = best_reg;
    assign new_best   = new_best_reg;

    // ------------------------------------------------------------------
    // Digit stream of a frozen snapshot
    // ------------------------------------------------------------------
    typedef enum logic {
        DUMP_IDLE   = 1'b0,
        DUMP_STREAM = 1'b1
    } dump_state_t;

    dump_state_t             state_reg;
    dump_state_t             state_next;
    logic [W-1:0]            snapshot_reg;
    logic [W-1:0]            snapshot_next;
    logic [IW-1:0]           index_reg;
    logic [IW-1:0]           index_next;
    logic [3:0]              snap_digits [DIGITS_COUNT];
    logic [DIGITS_COUNT-1:0] upper_zero;

    // upper_zero[i]: snapshot digits i and everything above it are zero.
    generate
        for (genvar gi = 0; gi < DIGITS_COUNT; gi++) begin : g_snap_digit
            assign snap_digits[gi] = snapshot_reg[gi*4 +: 4];
            if (gi == DIGITS_COUNT - 1) begin : g_top
                assign upper_zero[gi] = (snapshot_reg[gi*4 +: 4] == 4'd0);
            end else begin : g_lower
                assign upper_zero[gi] = upper_zero[gi+1] && (snapshot_reg[gi*4 +: 4] == 4'd0);
            end
        end
    endgenerate

    // Dump state, snapshot and index registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= DUMP_IDLE;
            snapshot_reg <= '0;
            index_reg    <= '0;
        end else begin
            state_reg    <= state_next;
            snapshot_reg <= snapshot_next;
            index_reg    <= index_next;
        end
    end

    // Dump next-state and handshake outputs; fields hold while the renderer stalls.
    always_comb begin
        state_next    = state_reg;
        snapshot_next = snapshot_reg;
        index_next    = index_reg;
        busy          = 1'b0;
        digit_valid   = 1'b0;
        digit_data    = 4'd0;
        digit_blank   = 1'b0;
        digit_last    = 1'b0;
        case (state_reg)
            DUMP_IDLE: begin
                if (dump_start) begin
                    snapshot_next = score_reg;
                    index_next    = TOP_INDEX;
                    state_next    = DUMP_STREAM;
                end
            end
            DUMP_STREAM: begin
                busy        = 1'b1;
                digit_valid = 1'b1;
                digit_data  = snap_digits[index_reg];
                digit_last  = (index_reg == '0);
                // The LSD is never blanked so a zero score still shows "0".
                digit_blank = (index_reg != '0) && upper_zero[index_reg];
                if (digit_ready) begin
                    if (index_reg == '0) begin
                        state_next = DUMP_IDLE;
                    end else begin
                        index_next = index_reg - 1'b1;
                    end
                end
            end
            default: begin
                state_next = DUMP_IDLE;
            end
        endcase
    end

    assign digit_index = index_reg;

endmodule
